// File: rtl/ttl_video_pkg.sv
// Shared definitions for the TTL-style video serializer path.
package ttl_video_pkg;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_PLANES = 3;
    localparam int unsigned MAX_WIDTH  = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_e;

    // Mirror a MAX_WIDTH-bit vector; narrower words are pre-aligned to the top by the caller.
    function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] x);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(MAX_WIDTH); i++) begin
            r[i] = x[int'(MAX_WIDTH) - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ls166_plane.sv
// One bit-plane PISO: parallel load (optionally mirrored) or left shift with zero fill.
module ls166_plane
    import ttl_video_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             load,
    input  logic             rev,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] d_rev;

    // Align the word to the top of the helper's range so the mirror lands in the low bits.
    assign d_rev = WIDTH'(bit_reverse(MAX_WIDTH'(d) << (MAX_WIDTH - WIDTH)));

    // Load on transfer, otherwise shift toward the MSB on every enabled clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (ce) begin
            if (load) begin
                sr <= rev ? d_rev : d;
            end else begin
                sr <= {sr[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/ls166_pixel_serializer.sv
// Double-buffered multi-plane pixel serializer: hold register feeding per-plane shifters.
module ls166_pixel_serializer
    import ttl_video_pkg::*;
#(
    parameter int unsigned PLANES = DEF_PLANES,
    parameter int unsigned WIDTH  = DEF_WIDTH
) (
    input  logic                    CLK,
    input  logic                    CLR_N,
    input  logic                    CE,
    input  logic                    LD_VALID,
    output logic                    LD_READY,
    input  logic [PLANES*WIDTH-1:0] D,
    input  logic                    FLIP,
    output logic [PLANES-1:0]       PIX,
    output logic                    PIX_VALID,
    output logic                    UNDERRUN,
    input  logic                    UNDERRUN_CLR
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    shift_state_e            state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [PLANES*WIDTH-1:0] hold_q;
    logic                    hold_flip;
    logic                    hold_valid, hold_valid_nxt;
    logic                    ld_ready_q;
    logic                    underrun_q, underrun_nxt;
    logic                    transfer;
    logic                    accept;
    logic                    ur_set;

    // Shifter sequencing, hold handshake and underrun detection.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        transfer       = 1'b0;
        ur_set         = 1'b0;
        accept         = LD_VALID && ld_ready_q;
        hold_valid_nxt = hold_valid;
        underrun_nxt   = underrun_q;

        if (CE) begin
            case (state)
                ST_IDLE: begin
                    if (hold_valid) begin
                        transfer  = 1'b1;
                        state_nxt = ST_SHIFT;
                        cnt_nxt   = '0;
                    end else begin
                        ur_set = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == LAST) begin
                        cnt_nxt = '0;
                        if (hold_valid) begin
                            transfer = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            endcase
        end

        // A fresh accept wins over the transfer so neither word is lost.
        if (accept) begin
            hold_valid_nxt = 1'b1;
        end else if (transfer) begin
            hold_valid_nxt = 1'b0;
        end

        if (UNDERRUN_CLR) begin
            underrun_nxt = 1'b0;
        end else if (ur_set) begin
            underrun_nxt = 1'b1;
        end
    end

    // State, counter and status registers.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hold_valid <= 1'b0;
            ld_ready_q <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hold_valid <= hold_valid_nxt;
            ld_ready_q <= !hold_valid_nxt;
            underrun_q <= underrun_nxt;
        end
    end

    // Hold register captures the word and its flip attribute on accept.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            hold_q    <= '0;
            hold_flip <= 1'b0;
        end else if (accept) begin
            hold_q    <= D;
            hold_flip <= FLIP;
        end
    end

    for (genvar p = 0; p < int'(PLANES); p++) begin : g_plane
        ls166_plane #(.WIDTH(WIDTH)) u_plane (
            .clk   (CLK),
            .rst_n (CLR_N),
            .ce    (CE),
            .load  (transfer),
            .rev   (hold_flip),
            .d     (hold_q[p*WIDTH +: WIDTH]),
            .msb   (PIX[p])
        );
    end

    assign LD_READY  = ld_ready_q;
    assign PIX_VALID = (state == ST_SHIFT);
    assign UNDERRUN  = underrun_q;

endmodule

// File: tb/tb_ls166_pixel_serializer.sv
// Self-checking bench for ls166_pixel_serializer against a pixel-queue reference model.
module tb_ls166_pixel_serializer;

    localparam int P = 3;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         CLR_N = 1'b0;
    logic         CE = 1'b0;
    logic         LD_VALID = 1'b0;
    logic         LD_READY;
    logic [P*W-1:0] D = '0;
    logic         FLIP = 1'b0;
    logic [P-1:0] PIX;
    logic         PIX_VALID;
    logic         UNDERRUN;
    logic         UNDERRUN_CLR = 1'b0;

    int total = 0;
    int bad = 0;

    // Model: queue of pixels still to show (front is on PIX), plus the pending hold word.
    int unsigned cur_q[$];
    int unsigned m_hold[W];
    bit          m_hv;
    bit          m_ur;
    int          m_acc;

    ls166_pixel_serializer dut (
        .CLK          (CLK),
        .CLR_N        (CLR_N),
        .CE           (CE),
        .LD_VALID     (LD_VALID),
        .LD_READY     (LD_READY),
        .D            (D),
        .FLIP         (FLIP),
        .PIX          (PIX),
        .PIX_VALID    (PIX_VALID),
        .UNDERRUN     (UNDERRUN),
        .UNDERRUN_CLR (UNDERRUN_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cur_q.delete();
        m_hv = 0;
        m_ur = 0;
        for (int i = 0; i < W; i++) m_hold[i] = 0;
    endtask

    task automatic check_outputs(input string tag);
        int unsigned exp_pix;
        exp_pix = (cur_q.size() > 0) ? cur_q[0] : 0;
        chk({tag, "_pix"}, 32'(PIX), exp_pix);
        chk({tag, "_pix_valid"}, 32'(PIX_VALID), (cur_q.size() > 0) ? 1 : 0);
        chk({tag, "_ld_ready"}, 32'(LD_READY), m_hv ? 0 : 1);
        chk({tag, "_underrun"}, 32'(UNDERRUN), m_ur ? 1 : 0);
    endtask

    // Advance the model with the inputs as seen before the edge, clock, then compare.
    task automatic tick(input string tag);
        bit hv0;
        bit urs;
        hv0 = m_hv;
        urs = 0;
        if (!CLR_N) begin
            model_reset();
        end else begin
            if (CE) begin
                if (cur_q.size() <= 1) begin
                    if (cur_q.size() == 0 && !m_hv) urs = 1;
                    cur_q.delete();
                    if (m_hv) begin
                        for (int i = 0; i < W; i++) cur_q.push_back(m_hold[i]);
                        m_hv = 0;
                    end
                end else begin
                    void'(cur_q.pop_front());
                end
            end
            if (LD_VALID && !hv0) begin
                for (int i = 0; i < W; i++) begin
                    int unsigned px;
                    px = 0;
                    for (int p = 0; p < P; p++) begin
                        if (FLIP ? D[p*W + i] : D[p*W + W - 1 - i]) px |= (1 << p);
                    end
                    m_hold[i] = px;
                end
                m_hv = 1;
                m_acc++;
            end
            if (UNDERRUN_CLR) m_ur = 0;
            else if (urs) m_ur = 1;
        end
        @(posedge CLK);
        #1;
        check_outputs(tag);
    endtask

    task automatic load_word(input logic [P*W-1:0] w, input logic f, input string tag);
        LD_VALID = 1'b1;
        D = w;
        FLIP = f;
        tick(tag);
        LD_VALID = 1'b0;
    endtask

    task automatic clear_underrun(input string tag);
        UNDERRUN_CLR = 1'b1;
        tick(tag);
        UNDERRUN_CLR = 1'b0;
    endtask

    initial begin
        int streak;
        int best;
        bit seen_idle;

        // Reset state
        model_reset();
        m_acc = 0;
        #12;
        check_outputs("reset");
        @(posedge CLK);
        #1;
        CLR_N = 1'b1;
        tick("post_reset");

        // Single word, no flip
        load_word(24'hFF_0F_A5, 1'b0, "single_ld");
        CE = 1'b1;
        for (int i = 0; i < 11; i++) tick("single");
        clear_underrun("single_clr");

        // Same data, flipped
        CE = 1'b0;
        load_word(24'hFF_0F_A5, 1'b1, "flip_ld");
        CE = 1'b1;
        for (int i = 0; i < 11; i++) tick("flip");
        clear_underrun("flip_clr");

        // Back-to-back words with LD_VALID held until two are accepted
        CE = 1'b0;
        tick("b2b_pre");
        CE = 1'b1;
        m_acc = 0;
        streak = 0;
        best = 0;
        LD_VALID = 1'b1;
        for (int i = 0; i < 22; i++) begin
            D = 24'($urandom);
            FLIP = 1'($urandom_range(0, 1));
            if (m_acc >= 2) LD_VALID = 1'b0;
            tick("b2b");
            if (PIX_VALID) streak++;
            else streak = 0;
            if (streak > best) best = streak;
        end
        LD_VALID = 1'b0;
        chk("b2b_streak", 32'(best), 16);
        clear_underrun("b2b_clr");

        // CE gating: CE alternates while words are offered in both CE phases
        for (int i = 0; i < 40; i++) begin
            CE = 1'(i % 2);
            LD_VALID = (i % 7 == 2) || (i % 11 == 5);
            D = 24'($urandom);
            FLIP = 1'($urandom_range(0, 1));
            tick("ce_gate");
        end
        LD_VALID = 1'b0;

        // Underrun after drain
        CE = 1'b1;
        clear_underrun("ur_pre");
        load_word(24'($urandom), 1'b0, "ur_ld");
        seen_idle = 0;
        for (int i = 0; i < 20 && !seen_idle; i++) begin
            tick("ur_drain");
            if (!PIX_VALID) seen_idle = 1;
        end
        chk("ur_drained", 32'(seen_idle), 1);
        tick("ur_set");
        chk("ur_sticky_set", 32'(UNDERRUN), 1);
        tick("ur_hold");
        chk("ur_sticky_hold", 32'(UNDERRUN), 1);
        clear_underrun("ur_clr");
        chk("ur_cleared", 32'(UNDERRUN), 0);

        // Reset in the middle of a word
        CE = 1'b0;
        load_word(24'hA5_3C_F0, 1'b0, "rst_ld");
        CE = 1'b1;
        for (int i = 0; i < 3; i++) tick("rst_shift");
        #2;
        CLR_N = 1'b0;
        #1;
        model_reset();
        chk("rst_async_pix", 32'(PIX), 0);
        chk("rst_async_valid", 32'(PIX_VALID), 0);
        chk("rst_async_ready", 32'(LD_READY), 1);
        tick("rst_hold");
        CLR_N = 1'b1;
        for (int i = 0; i < 10; i++) tick("rst_after");
        clear_underrun("rst_clr");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            CE = ($urandom_range(0, 3) != 0);
            LD_VALID = 1'($urandom_range(0, 1));
            D = 24'($urandom);
            FLIP = 1'($urandom_range(0, 1));
            UNDERRUN_CLR = ($urandom_range(0, 15) == 0);
            tick("rand");
        end
        UNDERRUN_CLR = 1'b0;
        LD_VALID = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
